// File: rtl/tpu_host_seq.sv
// Host-side sequencer for the TPU pin bus.
// Takes one 2x2 int8 matmul job, streams the weight and activation bytes,
// pulses start, waits for done, reads the 8 result bytes back, and returns
// four int16 results over a valid/ready handshake.
// Every output comes straight from a flop. Each output's next value is decoded
// from the next state, so a pin changes on the same edge as the state.
module tpu_host_seq #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_w,
   input  logic [31:0] job_a,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic        err_timeout,
   output logic        busy,
   output logic [7:0]  pin_ui,
   output logic        pin_load,
   output logic        pin_sel,
   output logic        pin_start,
   output logic        pin_rd_adv,
   input  logic [7:0]  pin_uo,
   input  logic        pin_done
);

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_A,
      START,
      WAIT_DONE,
      READ,
      RESP
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next, cnt_inc;
   logic [31:0] w_reg, w_next, a_reg, a_next;
   logic [31:0] w_src;
   logic [7:0]  w_byte [4];
   logic [7:0]  a_byte [4];
   logic [63:0] res_data_reg, res_data_next;
   logic [7:0]  capture_en;

   logic        job_ready_reg, job_ready_next;
   logic        busy_reg, busy_next;
   logic        res_valid_reg, res_valid_next;
   logic        err_reg, err_next;
   logic [7:0]  pin_ui_reg, pin_ui_next;
   logic        pin_load_reg, pin_load_next;
   logic        pin_sel_reg, pin_sel_next;
   logic        pin_start_reg, pin_start_next;
   logic        pin_rd_adv_reg, pin_rd_adv_next;

   assign cnt_inc = cnt_reg + 16'd1;

   // The first weight byte goes out on the accept edge itself, before w_reg
   // has been loaded. So while in IDLE the bytes come from the input bus.
   assign w_src = (state_reg == IDLE) ? job_w : w_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_job_bytes
         assign w_byte[gi] = w_src[8*gi +: 8];
         assign a_byte[gi] = a_reg[8*gi +: 8];
      end
      // READ alternates sample and advance cycles.
      // Even counts sample byte cnt/2 into its lane of the result.
      for (genvar gi = 0; gi < 8; gi++) begin : g_res_bytes
         assign capture_en[gi] = (state_reg == READ) && !cnt_reg[0] && (cnt_reg[3:1] == 3'(gi));
         assign res_data_next[8*gi +: 8] = capture_en[gi] ? pin_uo : res_data_reg[8*gi +: 8];
      end
   endgenerate

   // Next-state logic: sequencing, the per-phase counter and the timeout abort.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      w_next     = w_reg;
      a_next     = a_reg;
      err_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (job_valid) begin
               w_next     = job_w;
               a_next     = job_a;
               cnt_next   = 16'd0;
               state_next = LOAD_W;
            end
         end
         LOAD_W: begin
            if (cnt_reg == 16'd3) begin
               cnt_next   = 16'd0;
               state_next = LOAD_A;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         LOAD_A: begin
            if (cnt_reg == 16'd3) begin
               cnt_next   = 16'd0;
               state_next = START;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         START: begin
            cnt_next   = 16'd0;
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            // Done is checked first, so it wins on the final timeout cycle.
            if (pin_done) begin
               cnt_next   = 16'd0;
               state_next = READ;
            end else if (cnt_inc == TIMEOUT_LIMIT) begin
               cnt_next   = 16'd0;
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         READ: begin
            if (cnt_reg == 16'd15) begin
               cnt_next   = 16'd0;
               state_next = RESP;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         RESP: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode from the next state, so the registered pins line up with the state.
   always_comb begin
      job_ready_next  = (state_next == IDLE);
      busy_next       = (state_next != IDLE);
      pin_load_next   = (state_next == LOAD_W) || (state_next == LOAD_A);
      pin_sel_next    = (state_next == LOAD_A);
      pin_start_next  = (state_next == START);
      res_valid_next  = (state_next == RESP);
      // The last slot of READ carries no advance, because no byte follows it.
      pin_rd_adv_next = (state_next == READ) && cnt_next[0] && (cnt_next != 16'd15);
      pin_ui_next     = 8'h00;
      if (state_next == LOAD_W) begin
         pin_ui_next = w_byte[cnt_next[1:0]];
      end else if (state_next == LOAD_A) begin
         pin_ui_next = a_byte[cnt_next[1:0]];
      end
   end

   // State, job latches, result register and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= 16'd0;
         w_reg          <= 32'd0;
         a_reg          <= 32'd0;
         res_data_reg   <= 64'd0;
         job_ready_reg  <= 1'b1;
         busy_reg       <= 1'b0;
         res_valid_reg  <= 1'b0;
         err_reg        <= 1'b0;
         pin_ui_reg     <= 8'h00;
         pin_load_reg   <= 1'b0;
         pin_sel_reg    <= 1'b0;
         pin_start_reg  <= 1'b0;
         pin_rd_adv_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         w_reg          <= w_next;
         a_reg          <= a_next;
         res_data_reg   <= res_data_next;
         job_ready_reg  <= job_ready_next;
         busy_reg       <= busy_next;
         res_valid_reg  <= res_valid_next;
         err_reg        <= err_next;
         pin_ui_reg     <= pin_ui_next;
         pin_load_reg   <= pin_load_next;
         pin_sel_reg    <= pin_sel_next;
         pin_start_reg  <= pin_start_next;
         pin_rd_adv_reg <= pin_rd_adv_next;
      end
   end

   assign job_ready   = job_ready_reg;
   assign busy        = busy_reg;
   assign res_valid   = res_valid_reg;
   assign res_data    = res_data_reg;
   assign err_timeout = err_reg;
   assign pin_ui      = pin_ui_reg;
   assign pin_load    = pin_load_reg;
   assign pin_sel     = pin_sel_reg;
   assign pin_start   = pin_start_reg;
   assign pin_rd_adv  = pin_rd_adv_reg;

endmodule

// File: tb/tb_tpu_host_seq.sv
// Testbench for tpu_host_seq.
// A behavioural TPU model records the bytes it receives and the start and
// advance pulses it sees, and it serves result bytes through a read pointer.
// Expected latencies and results are worked out from the job timing rules.
module tb_tpu_host_seq;

   localparam int TMO   = 10;
   localparam int NEVER = 100000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [31:0] job_w = 32'd0;
   logic [31:0] job_a = 32'd0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [63:0] res_data;
   logic        err_timeout;
   logic        busy;
   logic [7:0]  pin_ui;
   logic        pin_load, pin_sel, pin_start, pin_rd_adv;
   logic [7:0]  pin_uo = 8'h00;
   logic        pin_done = 1'b0;

   int checks = 0;
   int failures = 0;
   int inv_viol = 0;
   bit armed = 1'b0;
   logic err_prev = 1'b0;

   // TPU model state
   logic [7:0] rb [8];
   logic [7:0] rx_w [$];
   logic [7:0] rx_a [$];
   int n_start = 0, n_adv = 0, ptr = 0, since = 0, done_delay = NEVER;
   bit started = 1'b0;

   tpu_host_seq #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_w(job_w), .job_a(job_a),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .err_timeout(err_timeout), .busy(busy),
      .pin_ui(pin_ui), .pin_load(pin_load), .pin_sel(pin_sel), .pin_start(pin_start),
      .pin_rd_adv(pin_rd_adv), .pin_uo(pin_uo), .pin_done(pin_done)
   );

   always #5 clk = ~clk;

   // The TPU side observes the pins mid-cycle and updates its own inputs away from the edge.
   always @(negedge clk) begin
      if (rst) begin
         ptr = 0; started = 1'b0; since = 0; pin_done = 1'b0; pin_uo = 8'h00;
      end else begin
         if (pin_load) begin
            started = 1'b0;
            if (pin_sel) rx_a.push_back(pin_ui);
            else         rx_w.push_back(pin_ui);
         end
         if (pin_start) begin
            n_start++; started = 1'b1; since = 0; ptr = 0;
         end else if (started) begin
            since++;
         end
         if (pin_rd_adv) begin
            n_adv++; ptr++;
         end
         pin_done = started && (since >= done_delay);
         pin_uo   = (ptr < 8) ? rb[ptr] : 8'h00;
      end
   end

   // Pin-bus invariants, checked every cycle and reported once at the end.
   always @(negedge clk) begin
      if (armed) begin
         if (!pin_load && pin_ui !== 8'h00) inv_viol++;
         if ((int'(pin_load) + int'(pin_start) + int'(pin_rd_adv)) > 1) inv_viol++;
         if (busy !== !job_ready) inv_viol++;
         if (err_timeout && err_prev) inv_viol++;
         if (err_timeout && res_valid) inv_viol++;
         err_prev = err_timeout;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_rand_bytes();
      for (int b = 0; b < 8; b++) rb[b] = 8'($urandom_range(0, 255));
   endtask

   // One complete job. abort_n != 0 applies reset in that cycle after accept.
   task automatic run_job(input logic [31:0] w, input logic [31:0] a, input int delay,
                          input int resp_wait, input bit poke, input int abort_n);
      int n, d_eff;
      bit got_res, got_err, stable;
      logic [63:0] exp_res, held;
      logic [31:0] gw, ga;
      exp_res = 64'd0;
      for (int b = 0; b < 8; b++) exp_res[8*b +: 8] = rb[b];
      d_eff = (delay < 1) ? 1 : delay;
      done_delay = delay;
      n = 0;
      while (job_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("ready_before_job", job_ready, 1'b1);
      rx_w.delete(); rx_a.delete(); n_start = 0; n_adv = 0;
      job_valid = 1'b1; job_w = w; job_a = a;
      @(negedge clk);
      job_valid = 1'b0; job_w = $urandom; job_a = $urandom;
      check("first_pin", {job_ready, pin_load, pin_sel, pin_ui}, {1'b0, 1'b1, 1'b0, w[7:0]});
      n = 1; got_res = 1'b0; got_err = 1'b0;
      while (n < 200) begin
         if (abort_n != 0 && n == abort_n) break;
         if (res_valid === 1'b1) begin got_res = 1'b1; break; end
         if (err_timeout === 1'b1) begin got_err = 1'b1; break; end
         @(negedge clk); n++;
      end
      if (abort_n != 0) begin
         check("adv_before_abort", n_adv, 3);
         rst = 1'b1;
         @(negedge clk);
         check("abort_outputs",
               {job_ready, busy, res_valid, err_timeout, pin_ui, pin_load, pin_sel, pin_start, pin_rd_adv},
               {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
         check("abort_res_data", res_data, 64'd0);
         rst = 1'b0;
         @(negedge clk);
         $display("job w=%08h a=%08h aborted by reset at cycle %0d", w, a, n);
         return;
      end
      gw = 32'd0; ga = 32'd0;
      for (int i = 0; i < rx_w.size() && i < 4; i++) gw[8*i +: 8] = rx_w[i];
      for (int i = 0; i < rx_a.size() && i < 4; i++) ga[8*i +: 8] = rx_a[i];
      check("weight_bytes", {32'(rx_w.size()), gw}, {32'd4, w});
      check("act_bytes", {32'(rx_a.size()), ga}, {32'd4, a});
      check("start_pulses", n_start, 1);
      if (delay > TMO) begin
         check("timeout_seen", {got_err, got_res}, 2'b10);
         check("timeout_latency", n, 10 + TMO);
         check("timeout_idle", {job_ready, busy, res_valid}, 3'b100);
         @(negedge clk);
         check("timeout_pulse_end", {err_timeout, res_valid, job_ready}, 3'b001);
         $display("job w=%08h a=%08h delay=%0d timeout at cycle %0d", w, a, delay, n);
         return;
      end
      check("result_seen", {got_res, got_err}, 2'b10);
      check("result_latency", n, 26 + d_eff);
      check("res_data", res_data, exp_res);
      check("adv_pulses", n_adv, 7);
      held = res_data; stable = 1'b1;
      for (int i = 0; i < resp_wait; i++) begin
         if (poke) begin job_valid = 1'b1; job_w = $urandom; job_a = $urandom; end
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== held || job_ready !== 1'b0 || pin_load !== 1'b0)
            stable = 1'b0;
      end
      check("resp_hold", stable, 1'b1);
      job_valid = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("after_transfer", {res_valid, job_ready, busy}, 3'b010);
      check("no_extra_load", rx_w.size(), 4);
      $display("job w=%08h a=%08h delay=%0d wait=%0d result=%016h cycles=%0d",
               w, a, delay, resp_wait, res_data, n);
   endtask

   initial begin
      logic [31:0] rw, ra;
      int rd, rr;
      for (int b = 0; b < 8; b++) rb[b] = 8'h00;
      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {job_ready, busy, res_valid, err_timeout, pin_ui, pin_load, pin_sel, pin_start, pin_rd_adv},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
      check("reset_res_data", res_data, 64'd0);
      rst = 1'b0; armed = 1'b1;
      @(negedge clk);

      // Directed job with known bytes and a done delay of 5
      rb[0] = 8'h13; rb[1] = 8'h00; rb[2] = 8'h16; rb[3] = 8'h00;
      rb[4] = 8'h2B; rb[5] = 8'h00; rb[6] = 8'h32; rb[7] = 8'h00;
      run_job(32'h04030201, 32'h08070605, 5, 1, 1'b0, 0);
      check("directed_result", res_data, 64'h0032_002B_0016_0013);

      // Done never arrives: abort with a timeout
      set_rand_bytes();
      run_job($urandom, $urandom, NEVER, 1, 1'b0, 0);
      check("res_kept_after_timeout", res_data, 64'h0032_002B_0016_0013);

      // Slow consumer, with a second job offered while results are held
      set_rand_bytes();
      run_job($urandom, $urandom, 3, 20, 1'b1, 0);

      // Reset during READ on byte 3 (done delay 5 puts byte 3's sample at cycle 21)
      set_rand_bytes();
      run_job($urandom, $urandom, 5, 1, 1'b0, 21);
      set_rand_bytes();
      run_job($urandom, $urandom, 4, 2, 1'b0, 0);

      // Done arrives on the timeout cycle, and done is already high on entry
      set_rand_bytes();
      run_job($urandom, $urandom, TMO, 1, 1'b0, 0);
      set_rand_bytes();
      run_job($urandom, $urandom, 0, 1, 1'b0, 0);

      // Random jobs; delays above the timeout exercise the abort path
      for (int j = 0; j < 8; j++) begin
         set_rand_bytes();
         rw = $urandom; ra = $urandom;
         rd = $urandom_range(0, TMO + 2);
         rr = $urandom_range(1, 4);
         run_job(rw, ra, rd, rr, 1'b0, 0);
      end

      check("pin_invariants", inv_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
